// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
// CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        JALR_A,
        JALR_B,
        LUI,
        AUIPC
`ifdef CTRL_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    // Must match the immediate extender's select encoding.
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_B = 3'b001,
        IMM_S = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [3:0] {
        ALUC_ADD = 4'b0000,
        ALUC_SUB = 4'b0001,
        ALUC_AND = 4'b0010,
        ALUC_OR  = 4'b0011,
        ALUC_XOR = 4'b0100,
        ALUC_SLT = 4'b0101,
        ALUC_SLL = 4'b0110,
        ALUC_SRL = 4'b0111,
        ALUC_SRA = 4'b1000
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
            OP_STORE:                 return IMM_S;
            OP_BRANCH:                return IMM_B;
            OP_LUI, OP_AUIPC:         return IMM_U;
            OP_JAL:                   return IMM_J;
            default:                  return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle: IR fields and flags in, selects and enables out.
interface multicycle_control_if;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic       Zero_i;
    logic       Lt_i;
    logic       MemReady_i;
    logic       MemReq_o;
    logic       MemWrite_o;
    logic       AdrSrc_o;
    logic       IRWrite_o;
    logic       PCWrite_o;
    logic       RegWrite_o;
    logic [2:0] ImmSrc_o;
    logic [1:0] ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [3:0] ALUControl_o;
    logic [1:0] ResultSrc_o;
    logic       Trap_o;

    modport master (
        input  op_i, funct3_i, funct7b5_i, Zero_i, Lt_i, MemReady_i,
        output MemReq_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o,
        output RegWrite_o, ImmSrc_o, ALUSrcA_o, ALUSrcB_o,
        output ALUControl_o, ResultSrc_o, Trap_o
    );

    modport slave (
        output op_i, funct3_i, funct7b5_i, Zero_i, Lt_i, MemReady_i,
        input  MemReq_o, MemWrite_o, AdrSrc_o, IRWrite_o, PCWrite_o,
        input  RegWrite_o, ImmSrc_o, ALUSrcA_o, ALUSrcB_o,
        input  ALUControl_o, ResultSrc_o, Trap_o
    );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request and the instruction funct fields to ALUControl.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        is_rtype,
    output alu_ctrl_t   alu_ctrl
);

    always_comb begin
        alu_ctrl = ALUC_ADD;
        unique case (alu_op)
            ALUOP_SUB: alu_ctrl = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 is an immediate bit for addi, so only R-type subtracts
                    3'b000: alu_ctrl = (is_rtype && funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b001: alu_ctrl = ALUC_SLL;
                    3'b010: alu_ctrl = ALUC_SLT;
                    3'b011: alu_ctrl = ALUC_SLT;
                    3'b100: alu_ctrl = ALUC_XOR;
                    3'b101: alu_ctrl = funct7b5 ? ALUC_SRA : ALUC_SRL;
                    3'b110: alu_ctrl = ALUC_OR;
                    default: alu_ctrl = ALUC_AND;
                endcase
            end
            default: alu_ctrl = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of skipping them.
module multicycle_control
    import ctrl_pkg::*;
(
    input logic                  clk_i,
    input logic                  rst_i,
    multicycle_control_if.master bus
);

    state_t     state, next;
    logic       mem_req, mem_write, adr_src;
    logic       ir_write, pc_write, reg_write;
    logic [1:0] src_a, src_b, res_src;
    logic       br_taken;
    alu_op_t    alu_op;
    alu_ctrl_t  alu_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       trap;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        case (bus.funct3_i)
            3'b000:  br_taken = bus.Zero_i;
            3'b001:  br_taken = !bus.Zero_i;
            3'b100:  br_taken = bus.Lt_i;
            3'b101:  br_taken = !bus.Lt_i;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        next      = state;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        adr_src   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        src_a     = SRCA_PC;
        src_b     = SRCB_RS2;
        res_src   = RES_ALUOUT;
        alu_op    = ALUOP_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap      = 1'b0;
`endif
        unique case (state)
            FETCH: begin
                mem_req  = 1'b1;
                src_b    = SRCB_FOUR;
                res_src  = RES_ALURES;
                ir_write = bus.MemReady_i;
                pc_write = bus.MemReady_i;
                if (bus.MemReady_i) next = DECODE;
            end
            DECODE: begin
                // Branch/jal target parks in ALUOut for the next state
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (bus.op_i)
                    OP_LOAD, OP_STORE: next = MEMADR;
                    OP_R:              next = EXECR;
                    OP_IMM:            next = EXECI;
                    OP_BRANCH:         next = BRANCH;
                    OP_JAL:            next = JAL;
                    OP_JALR:           next = JALR_A;
                    OP_LUI:            next = LUI;
                    OP_AUIPC:          next = AUIPC;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        next = TRAP;
`else
                        next = FETCH;
`endif
                    end
                endcase
            end
            MEMADR: begin
                src_a = SRCA_RS1;
                src_b = SRCB_IMM;
                next  = (bus.op_i == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.MemReady_i) next = MEMWB;
            end
            MEMWB: begin
                res_src   = RES_RDATA;
                reg_write = 1'b1;
                next      = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.MemReady_i) next = FETCH;
            end
            EXECR: begin
                src_a  = SRCA_RS1;
                alu_op = ALUOP_FUNCT;
                next   = ALUWB;
            end
            EXECI: begin
                src_a  = SRCA_RS1;
                src_b  = SRCB_IMM;
                alu_op = ALUOP_FUNCT;
                next   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                next      = FETCH;
            end
            BRANCH: begin
                src_a    = SRCA_RS1;
                alu_op   = ALUOP_SUB;
                pc_write = br_taken;
                next     = FETCH;
            end
            JAL: begin
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                next     = ALUWB;
            end
            JALR_A: begin
                src_a    = SRCA_RS1;
                src_b    = SRCB_IMM;
                res_src  = RES_ALURES;
                pc_write = 1'b1;
                next     = JALR_B;
            end
            JALR_B: begin
                src_a     = SRCA_OLDPC;
                src_b     = SRCB_FOUR;
                res_src   = RES_ALURES;
                reg_write = 1'b1;
                next      = FETCH;
            end
            LUI: begin
                res_src   = RES_IMM;
                reg_write = 1'b1;
                next      = FETCH;
            end
            AUIPC: begin
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                next  = ALUWB;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: trap = 1'b1;
`endif
            default: next = FETCH;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op   (alu_op),
        .funct3   (bus.funct3_i),
        .funct7b5 (bus.funct7b5_i),
        .is_rtype (bus.op_i == OP_R),
        .alu_ctrl (alu_ctrl)
    );

    // Gate with rst_i so an in-flight write dies the instant reset rises
    assign bus.MemReq_o     = mem_req & ~rst_i;
    assign bus.MemWrite_o   = mem_write & ~rst_i;
    assign bus.AdrSrc_o     = adr_src & ~rst_i;
    assign bus.IRWrite_o    = ir_write & ~rst_i;
    assign bus.PCWrite_o    = pc_write & ~rst_i;
    assign bus.RegWrite_o   = reg_write & ~rst_i;
    assign bus.ImmSrc_o     = rst_i ? 3'b000 : imm_src_of(bus.op_i);
    assign bus.ALUSrcA_o    = rst_i ? 2'b00 : src_a;
    assign bus.ALUSrcB_o    = rst_i ? 2'b00 : src_b;
    assign bus.ALUControl_o = rst_i ? 4'b0000 : alu_ctrl;
    assign bus.ResultSrc_o  = rst_i ? 2'b00 : res_src;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.Trap_o       = trap & ~rst_i;
`else
    assign bus.Trap_o       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction stream.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mreq, mwr, adr, irw, pcw, rw, trap;
        logic [2:0] imm;
        logic [1:0] sa, sb;
        logic [3:0] ac;
        logic [1:0] res;
    } obs_t;

    typedef struct {
        logic rdy;
        obs_t v;
        obs_t m;
    } cyc_t;

    cyc_t       q[$];
    logic [2:0] cur_imm;
    logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                             7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                             7'b0010111, 7'b0000000};

    function automatic obs_t observe();
        obs_t o;
        o.mreq = bus.MemReq_o;     o.mwr = bus.MemWrite_o;
        o.adr  = bus.AdrSrc_o;     o.irw = bus.IRWrite_o;
        o.pcw  = bus.PCWrite_o;    o.rw  = bus.RegWrite_o;
        o.trap = bus.Trap_o;       o.imm = bus.ImmSrc_o;
        o.sa   = bus.ALUSrcA_o;    o.sb  = bus.ALUSrcB_o;
        o.ac   = bus.ALUControl_o; o.res = bus.ResultSrc_o;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] spec_imm(input logic [6:0] op);
        if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111) return 3'b000;
        if (op == 7'b0100011) return 3'b010;
        if (op == 7'b1100011) return 3'b001;
        if (op == 7'b0110111 || op == 7'b0010111) return 3'b011;
        if (op == 7'b1101111) return 3'b100;
        return 3'b000;
    endfunction

    function automatic int spec_alu(input logic [2:0] f3, input logic f7, input logic rtype);
        case (f3)
            3'd0: return (rtype && f7) ? 1 : 0;
            3'd1: return 6;
            3'd2: return 5;
            3'd4: return 4;
            3'd5: return f7 ? 8 : 7;
            3'd6: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.op_i = op;
        bus.funct3_i = f3;
        bus.funct7b5_i = f7;
    endtask

    // One expected cycle; negative select arguments mean "not specified here"
    task automatic phase(input logic rdy, input logic mreq, mwr, adr, irw, pcw, rw,
                         input int sa, sb, ac, res);
        cyc_t c;
        c.rdy = rdy;
        c.v = '0;
        c.m = '0;
        c.v.mreq = mreq; c.v.mwr = mwr; c.v.irw = irw; c.v.pcw = pcw; c.v.rw = rw;
        c.m.mreq = 1'b1; c.m.mwr = 1'b1; c.m.irw = 1'b1; c.m.pcw = 1'b1; c.m.rw = 1'b1;
        c.m.trap = 1'b1;
        c.v.imm = cur_imm; c.m.imm = '1;
        if (mreq) begin c.v.adr = adr; c.m.adr = 1'b1; end
        if (sa >= 0) begin c.v.sa = 2'(sa); c.m.sa = '1; end
        if (sb >= 0) begin c.v.sb = 2'(sb); c.m.sb = '1; end
        if (ac >= 0) begin c.v.ac = 4'(ac); c.m.ac = '1; end
        if (res >= 0) begin c.v.res = 2'(res); c.m.res = '1; end
        q.push_back(c);
    endtask

    task automatic model(input int kind, input logic [2:0] f3, input logic f7,
                         input logic zero, input logic lt, input int fw, input int mw);
        logic taken;
        for (int i = 0; i < fw; i++) phase(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 2);
        phase(1, 1, 0, 0, 1, 1, 0, 0, 2, 0, 2);
        phase(rb(), 0, 0, 0, 0, 0, 0, 1, 1, 0, -1);
        case (kind)
            0: begin
                phase(rb(), 0, 0, 0, 0, 0, 0, 2, 1, 0, -1);
                for (int i = 0; i < mw; i++) phase(0, 1, 0, 1, 0, 0, 0, -1, -1, -1, -1);
                phase(1, 1, 0, 1, 0, 0, 0, -1, -1, -1, -1);
                phase(rb(), 0, 0, 0, 0, 0, 1, -1, -1, -1, 1);
            end
            1: begin
                phase(rb(), 0, 0, 0, 0, 0, 0, 2, 1, 0, -1);
                for (int i = 0; i < mw; i++) phase(0, 1, 1, 1, 0, 0, 0, -1, -1, -1, -1);
                phase(1, 1, 1, 1, 0, 0, 0, -1, -1, -1, -1);
            end
            2, 3: begin
                phase(rb(), 0, 0, 0, 0, 0, 0, 2, (kind == 2) ? 0 : 1,
                      spec_alu(f3, f7, kind == 2), -1);
                phase(rb(), 0, 0, 0, 0, 0, 1, -1, -1, -1, 0);
            end
            4: begin
                taken = (f3 == 0) ? zero : (f3 == 1) ? !zero :
                        (f3 == 4) ? lt : (f3 == 5) ? !lt : 1'b0;
                phase(rb(), 0, 0, 0, 0, taken, 0, 2, 0, 1, 0);
            end
            5: begin
                phase(rb(), 0, 0, 0, 0, 1, 0, 1, 2, 0, 0);
                phase(rb(), 0, 0, 0, 0, 0, 1, -1, -1, -1, 0);
            end
            6: begin
                phase(rb(), 0, 0, 0, 0, 1, 0, 2, 1, 0, 2);
                phase(rb(), 0, 0, 0, 0, 0, 1, 1, 2, 0, 2);
            end
            7: phase(rb(), 0, 0, 0, 0, 0, 1, -1, -1, -1, 3);
            8: begin
                phase(rb(), 0, 0, 0, 0, 0, 0, 1, 1, 0, -1);
                phase(rb(), 0, 0, 0, 0, 0, 1, -1, -1, -1, 0);
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        obs_t o;
        set_instr(7'b0100011, 3'b010, 1'b0);
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", o);
        end
        tick();
        rst = 1'b0;
        bus.MemReady_i = 1'b1;
        @(negedge clk);
        o = observe();
        checks++;
        if (!(o.mreq === 1 && o.adr === 0 && o.irw === 1 && o.sb === 2 && o.res === 2)) begin
            failures++;
            $display("FAIL reset_fetch got=%h want=mreq,irw,sb=2,res=2", o);
        end
        tick();
        tick();
        tick();
        bus.MemReady_i = 1'b0;
        @(negedge clk);
        o = observe();
        checks++;
        if (!(o.mreq === 1 && o.mwr === 1 && o.adr === 1)) begin
            failures++;
            $display("FAIL memwrite_hold got=%h want=mreq,mwr,adr", o);
        end
        #1 rst = 1'b1;
        #1;
        o = observe();
        checks++;
        if (o.mwr !== 1'b0 || o !== '0) begin
            failures++;
            $display("FAIL reset_midwrite got=%h want=0", o);
        end
        tick();
        rst = 1'b0;
        set_instr(7'b0110111, 3'b000, 1'b0);
        bus.MemReady_i = 1'b1;
        @(negedge clk);
        o = observe();
        checks++;
        if (!(o.mreq === 1 && o.adr === 0 && o.mwr === 0)) begin
            failures++;
            $display("FAIL reset_release got=%h want=fetch", o);
        end
        tick();
        @(negedge clk);
        o = observe();
        checks++;
        if (o.sa !== 2'b01 || o.rw !== 1'b0) begin
            failures++;
            $display("FAIL lui_decode got=%h want=sa=01", o);
        end
        tick();
        @(negedge clk);
        o = observe();
        checks++;
        if (o.rw !== 1'b1 || o.res !== 2'b11 || o.imm !== 3'b011) begin
            failures++;
            $display("FAIL lui_wb got=%h want=rw,res=11,imm=011", o);
        end
        tick();
    endtask

    task automatic test_fetch_idle(input string name);
        obs_t o;
        bus.MemReady_i = 1'b0;
        @(negedge clk);
        o = observe();
        checks++;
        if (!(o.mreq === 1 && o.adr === 0 && o.irw === 0 && o.rw === 0 && o.trap === 0)) begin
            failures++;
            $display("FAIL %s_fetch got=%h want=fetch", name, o);
        end
        tick();
    endtask

    task automatic test_add();
        obs_t o;
        logic [31:0] ins;
        ins = 32'h002081B3;
        set_instr(ins[6:0], ins[14:12], ins[30]);
        bus.MemReady_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            o = observe();
            checks++;
            if (o.rw !== (c == 4)) begin
                failures++;
                $display("FAIL add_regwrite c=%0d got=%b want=%b", c, o.rw, c == 4);
            end
            if (c == 3) begin
                checks++;
                if (o.ac !== 4'b0000 || o.sa !== 2'b10 || o.sb !== 2'b00) begin
                    failures++;
                    $display("FAIL add_execr got=%h want=ac0,sa2,sb0", o);
                end
            end
            tick();
        end
        test_fetch_idle("add");
    endtask

    task automatic test_lw_wait();
        obs_t o;
        int   held;
        held = 0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            bus.MemReady_i = (c == 1 || c == 7);
            @(negedge clk);
            o = observe();
            if (o.mreq === 1'b1 && o.adr === 1'b1) held++;
            checks++;
            if (o.rw !== (c == 8) || (c == 8 && o.res !== 2'b01)) begin
                failures++;
                $display("FAIL lw_wb c=%0d got=%h want_rw=%b", c, o, c == 8);
            end
            tick();
        end
        checks++;
        if (held != 4) begin
            failures++;
            $display("FAIL lw_req_held got=%0d want=4", held);
        end
        test_fetch_idle("lw");
    endtask

    task automatic test_branch();
        obs_t o;
        for (int b = 0; b < 2; b++) begin
            set_instr(7'b1100011, 3'(b), 1'b0);
            bus.Zero_i = 1'b1;
            bus.Lt_i = 1'b0;
            bus.MemReady_i = 1'b1;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                o = observe();
                checks++;
                if (o.imm !== 3'b001) begin
                    failures++;
                    $display("FAIL branch_imm b=%0d c=%0d got=%b want=001", b, c, o.imm);
                end
                if (c == 3) begin
                    checks++;
                    if (o.pcw !== (b == 0) || o.ac !== 4'b0001 || o.sa !== 2'b10) begin
                        failures++;
                        $display("FAIL branch_pcw b=%0d got=%h want_pcw=%b", b, o, b == 0);
                    end
                end
                tick();
            end
            test_fetch_idle("branch");
        end
    endtask

    task automatic test_jal();
        obs_t o;
        set_instr(7'b1101111, 3'b000, 1'b0);
        bus.MemReady_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            o = observe();
            checks++;
            if (o.imm !== 3'b100 || o.rw !== (c == 4)) begin
                failures++;
                $display("FAIL jal_imm_rw c=%0d got=%h want=imm100", c, o);
            end
            if (c == 3) begin
                checks++;
                if (o.pcw !== 1'b1 || o.res !== 2'b00) begin
                    failures++;
                    $display("FAIL jal_pcw got=%h want=pcw1,res00", o);
                end
            end
            tick();
        end
        test_fetch_idle("jal");
    endtask

    task automatic test_illegal();
        obs_t o;
        set_instr(7'b0000000, 3'b000, 1'b0);
        bus.MemReady_i = 1'b1;
        tick();
        @(negedge clk);
        o = observe();
        checks++;
        if ({o.mreq, o.mwr, o.irw, o.pcw, o.rw, o.trap} !== 6'b0) begin
            failures++;
            $display("FAIL illegal_decode got=%h want=no enables", o);
        end
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int c = 0; c < 4; c++) begin
            bus.MemReady_i = rb();
            @(negedge clk);
            o = observe();
            checks++;
            if (o.trap !== 1'b1 || {o.mreq, o.mwr, o.irw, o.pcw, o.rw} !== 5'b0) begin
                failures++;
                $display("FAIL illegal_trap c=%0d got=%h want=trap only", c, o);
            end
            tick();
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.Trap_o !== 1'b0) begin
            failures++;
            $display("FAIL trap_reset got=%b want=0", bus.Trap_o);
        end
        tick();
        rst = 1'b0;
`endif
        test_fetch_idle("illegal");
    endtask

    task automatic test_random();
        cyc_t c;
        obs_t o;
        int   kind, nk, fw, mw;
        logic [2:0] f3;
        logic f7, zero, lt;
`ifdef CTRL_ILLEGAL_TRAP_EN
        nk = 9;
`else
        nk = 10;
`endif
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, nk - 1);
            f3 = 3'($urandom_range(0, 7));
            if (kind == 2 || kind == 3) begin
                f3 = 3'($urandom_range(0, 6));
                if (f3 >= 3) f3 = f3 + 3'd1;
            end
            f7 = rb();
            zero = rb();
            lt = rb();
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 3);
            set_instr(ops[kind], f3, f7);
            bus.Zero_i = zero;
            bus.Lt_i = lt;
            cur_imm = spec_imm(ops[kind]);
            q.delete();
            model(kind, f3, f7, zero, lt, fw, mw);
            for (int k = 0; q.size() > 0; k++) begin
                c = q.pop_front();
                bus.MemReady_i = c.rdy;
                @(negedge clk);
                o = observe();
                checks++;
                if ((o & c.m) !== (c.v & c.m)) begin
                    failures++;
                    $display("FAIL random n=%0d kind=%0d cyc=%0d got=%h want=%h mask=%h",
                             n, kind, k, o & c.m, c.v & c.m, c.m);
                end
                tick();
            end
        end
        test_fetch_idle("random");
    endtask

    initial begin
        set_instr(7'b0, 3'b0, 1'b0);
        bus.Zero_i = 1'b0;
        bus.Lt_i = 1'b0;
        bus.MemReady_i = 1'b0;
        cur_imm = 3'b000;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Drives ImmSrc_o to the immediate extender, plus the mux selects and write enables for the PC, IR, register file and memory.
- Sits beside the datapath. It consumes the latched instruction fields and the ALU flags.

Parameters:
- None. Encodings are fixed in the shared package.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- op_i  in  7  IR[6:0]
- funct3_i  in  3  IR[14:12]
- funct7b5_i  in  1  IR[30]
- Zero_i  in  1  ALU result == 0
- Lt_i  in  1  signed less-than from the ALU subtract
- MemReady_i  in  1  memory completes the current request this cycle
- MemReq_o  out  1  memory access request, held until MemReady_i
- MemWrite_o  out  1  store strobe, qualified by MemReq_o
- AdrSrc_o  out  1  0 = PC, 1 = ALUOut
- IRWrite_o  out  1  latch IR and OldPC
- PCWrite_o  out  1  load PC from the result bus
- RegWrite_o  out  1  register-file write
- ImmSrc_o  out  3  000 I, 001 B, 010 S, 011 U, 100 J
- ALUSrcA_o  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB_o  out  2  00 rs2, 01 ImmExt, 10 const 4
- ALUControl_o  out  4  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl, 1000 sra
- ResultSrc_o  out  2  00 ALUOut, 01 read data, 10 ALUResult, 11 ImmExt
- Trap_o  out  1  illegal instruction (feature only, else tied 0)

Behaviour:
- Reset:
  - rst_i asynchronously forces state = FETCH.
  - While rst_i is high, MemReq_o, MemWrite_o, IRWrite_o, PCWrite_o, RegWrite_o and Trap_o are 0. All selects are 0.
  - After release, FETCH outputs apply from the next edge.
  - Reset mid-instruction abandons it. No partial write is issued after rst_i rises.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR_A, JALR_B, LUI, AUIPC.
- ImmSrc_o is a combinational function of op_i in every state:
  - load, op-imm, jalr → I
  - store → S
  - branch → B
  - lui, auipc → U
  - jal → J
  - otherwise 000
- FETCH:
  - MemReq=1, AdrSrc=0, SrcA=PC, SrcB=4, add, ResultSrc=10.
  - IRWrite and PCWrite = MemReady_i.
  - Stay in FETCH while MemReady_i=0. Otherwise go to DECODE.
- DECODE: SrcA=OldPC, SrcB=Imm, add (branch/jal target into ALUOut). Next state by op:
  - load/store → MEMADR
  - R-type → EXECR
  - op-imm → EXECI
  - branch → BRANCH
  - jal → JAL
  - jalr → JALR_A
  - lui → LUI
  - auipc → AUIPC
  - other → illegal handling (see feature)
- MEMADR: SrcA=rs1, SrcB=Imm, add. Go to MEMREAD for load, MEMWRITE for store.
- MEMREAD: MemReq=1, AdrSrc=1. Hold until MemReady_i, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Hold until MemReady_i, then FETCH.
- EXECR / EXECI: SrcA=rs1, SrcB = rs2 (EXECR) or Imm (EXECI); ALU decode from funct3/funct7b5. Then ALUWB.
  - sub only in R-type with funct7b5=1.
  - srai/sra when funct3=101 and funct7b5=1.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: SrcA=rs1, SrcB=rs2, sub, ResultSrc=00, then FETCH. PCWrite per funct3:
  - beq: Zero_i
  - bne: !Zero_i
  - blt: Lt_i
  - bge: !Lt_i
  - other funct3: PCWrite=0
- JAL: SrcA=OldPC, SrcB=4, add, ResultSrc=00, PCWrite=1, then ALUWB.
- JALR_A: SrcA=rs1, SrcB=Imm, add, ResultSrc=10, PCWrite=1. Target bit 0 is cleared by the datapath.
- JALR_B: SrcA=OldPC, SrcB=4, add, ResultSrc=10, RegWrite=1, then FETCH.
- LUI: ResultSrc=11, RegWrite=1, then FETCH.
- AUIPC: SrcA=OldPC, SrcB=Imm, add, then ALUWB.
- Latencies with MemReady_i=1 in the same cycle (FETCH counts as 1):
  - branch 3, lui 3
  - R-type/I-type 4, store 4, jal 4, jalr 4, auipc 4
  - load 5
- Each memory wait cycle adds 1.
- Requests are never dropped. MemReq_o stays high, with AdrSrc and MemWrite stable, until MemReady_i.

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN defined:
  - Unknown opcode in DECODE → TRAP state.
  - Trap_o=1, all enables 0.
  - Held until reset.
- Undefined: unknown opcode in DECODE → FETCH (executes as nop). State TRAP is absent and Trap_o is tied 0.

Decomposition:
- Package ctrl_pkg:
  - state_t enum
  - imm_src_t enum (must match the extender's encoding)
  - opcode localparams
  - alu_ctrl_t
  - result_src/alu_src localparams
- One sub-module, alu_decoder: a combinational mapping (add-only / sub-only / funct-decoded, funct3, funct7b5, is_rtype) → ALUControl_o.

Test Plan:
- Reset: rst_i pulsed mid-MEMWRITE → MemWrite_o=0 immediately; state FETCH after release.
- add x3,x1,x2 (0x002081B3), MemReady_i=1 → FETCH, DECODE, EXECR, ALUWB:
  - ALUControl_o=000 in EXECR
  - RegWrite_o=1 only in cycle 4
- lw (op 0000011) with MemReady_i low for 3 cycles in MEMREAD → MemReq_o held 4 cycles, AdrSrc_o=1; MEMWB reached; total 8 cycles.
- beq Zero_i=1, then bne Zero_i=1 → PCWrite_o=1 for the first, 0 for the second; ImmSrc_o=001 in both.
- jal (op 1101111) → ImmSrc_o=100; PCWrite_o=1 in JAL; RegWrite_o=1 in ALUWB.
- Opcode 0000000 → without the macro: FETCH next, no enables. With CTRL_ILLEGAL_TRAP_EN: Trap_o=1, held until rst_i.
